// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode type for the gray_counter slice.
// Helpers work on a fixed maximum-width word; callers zero-extend and truncate.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  // Binary to Gray: each bit is the XOR of itself and the next higher binary bit.
  function automatic gray_word_t b2g(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: bit i is the running parity of g from the MSB down to i.
  // Zero-extended upper bits leave the parity of narrower words unchanged.
  function automatic gray_word_t g2b(input gray_word_t g);
    gray_word_t b;
    logic       acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder; also used by CDC pointer comparators.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_c
);

  assign bin_c = WIDTH'(g2b(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_counter.sv
// Up/down counter holding its state in both binary and Gray code, with
// binary/Gray load, wrap or saturate at the range ends, and tc/wrap flags.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam count_mode_e      MODE     = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] load_dec_c;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  gray_to_binary #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .gray  (load_val),
    .bin_c (load_dec_c)
  );

  // Next-state: load beats count, count beats hold; range ends wrap or saturate.
  always_comb begin
    bin_next  = bin_out;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_is_gray ? load_dec_c : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (bin_out != MAX_VAL) begin
          bin_next = bin_out + WIDTH'(1);
        end else if (MODE == MODE_WRAP) begin
          bin_next  = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (bin_out != '0) begin
          bin_next = bin_out - WIDTH'(1);
        end else if (MODE == MODE_WRAP) begin
          bin_next  = MAX_VAL;
          wrap_next = 1'b1;
        end
      end
    end
    gray_next = WIDTH'(b2g(GRAY_MAX_W'(bin_next)));
  end

  // Gray is registered from the next binary value so it never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out    <= RST_BIN;
      gray_out   <= RST_GRAY;
      wrap_pulse <= 1'b0;
    end else begin
      bin_out    <= bin_next;
      gray_out   <= gray_next;
      wrap_pulse <= wrap_next;
    end
  end

  assign tc = up_dn ? (bin_out == MAX_VAL) : (bin_out == '0);

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
Parametrised up/down counter that holds its state in both binary and Gray code. Both codes are registered outputs, so gray_out is glitch-free and changes exactly one bit per count step. It succeeds the combinational binary-to-Gray converter and is intended for CDC pointer generation and position encoders. It adds count direction, a synchronous load in either code, wrap or saturate mode, and terminal-count and wrap flags.

Parameters:
WIDTH, 4, counter width in bits (>= 2)
SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the ends of the range
RESET_VAL, 0, binary value loaded on reset; must fit in WIDTH bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable, sampled on the clk rising edge
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe; has priority over en
load_is_gray  input  1  1 = load_val is Gray code, 0 = load_val is binary
load_val  input  WIDTH  value to load
bin_out  output  WIDTH  registered binary count
gray_out  output  WIDTH  registered Gray count; always equals bin_out ^ (bin_out >> 1)
tc  output  1  terminal count (combinational from state and up_dn)
wrap_pulse  output  1  registered, high for exactly one cycle after a wrap

Behaviour:
- Reset (rst_n low, asynchronous):
  - bin_out = RESET_VAL
  - gray_out = RESET_VAL ^ (RESET_VAL >> 1)
  - wrap_pulse = 0
- Release of rst_n is synchronised upstream; the block takes no action on deassertion. The first count can occur at the first clk edge with rst_n high.
- Priority per cycle: load > en > hold.
- load = 1:
  - bin_next = load_is_gray ? g2b(load_val) : load_val
  - gray_next = b2g(bin_next)
  - wrap_pulse = 0
  - takes effect in the cycle it is sampled, independent of en
- en = 1, load = 0, up_dn = 1:
  - bin_next = bin_out + 1, computed modulo 2^WIDTH
  - At bin_out = 2^WIDTH-1 with SATURATE=0: next value is 0 and wrap_pulse = 1 the next cycle.
  - At bin_out = 2^WIDTH-1 with SATURATE=1: value holds and wrap_pulse = 0.
- en = 1, load = 0, up_dn = 0:
  - bin_next = bin_out - 1
  - At bin_out = 0 with SATURATE=0: next value is 2^WIDTH-1 and wrap_pulse = 1.
  - At bin_out = 0 with SATURATE=1: value holds.
- en = 0, load = 0: state holds and wrap_pulse = 0.
- Latency: one clk from a sampled en/load to the new value on bin_out and gray_out.
- gray_out is registered from b2g(bin_next), never decoded combinationally from bin_out.
- Single-bit change: every count step, including a wrap, changes exactly one bit of gray_out. A saturated hold changes zero bits. A load may change any number of bits.
- tc = up_dn ? (bin_out == 2^WIDTH-1) : (bin_out == 0). It is valid regardless of en.
- up_dn may change on any cycle; the direction takes effect on the same sampling edge.
- g2b(g): bit i is the XOR of g[WIDTH-1:i]. It is a pure function with no added latency.
- No X propagation: with all inputs known, all outputs are known after reset.

Decomposition:
- Package gray_pkg:
  - function b2g(logic [WIDTH-1:0])
  - function g2b(logic [WIDTH-1:0]), written with a loop over the parameterised width
  - typedef enum {MODE_WRAP, MODE_SAT} count_mode_e, used to map SATURATE
- Sub-module gray_to_binary (parameter WIDTH, combinational): decodes load_val when load_is_gray = 1. It is reused later by CDC pointer comparators.
- Counter registers, next-state logic and flags live in gray_counter.

Test Plan:
1. Reset and count up (WIDTH=4, RESET_VAL=0, SATURATE=0):
   - Reset, then en=1, up_dn=1 for 17 cycles.
   - bin_out steps 0..15 then 0.
   - gray_out follows 0000, 0001, 0011, 0010, ..., 1000, then 0000.
   - wrap_pulse is high only in the cycle after the 15 -> 0 step.
   - tc is high while bin_out = 15.
2. Count down across the wrap:
   - Load binary 2, then en=1, up_dn=0 for 4 cycles.
   - bin_out goes 2, 1, 0, 15, 14; gray_out goes 0011, 0001, 0000, 1000, 1001.
   - wrap_pulse is high once, after the 0 -> 15 step; tc is high at bin_out = 0.
3. Saturate (SATURATE=1):
   - Load 14, then count up 3 cycles.
   - bin_out goes 14, 15, 15, 15; wrap_pulse never asserts; tc stays high.
   - Then up_dn=0: bin_out goes 14.
4. Gray load and priority:
   - load=1, load_is_gray=1, load_val=1101, en=1, all in the same cycle.
   - Next cycle: bin_out = 1001 (9), gray_out = 1101, with no increment applied.
   - Then load=1, load_is_gray=0, load_val=0110: bin_out = 6, gray_out = 0101.
5. Asynchronous reset mid-count (RESET_VAL=5):
   - Count to 11, then pulse rst_n low between clock edges.
   - Outputs immediately show bin_out = 5, gray_out = 0111, wrap_pulse = 0; counting resumes from 5.
6. Random regression (WIDTH=4 and WIDTH=8):
   - 1000 cycles with random en, up_dn, load, load_is_gray, load_val.
   - A reference model matches bin_out and gray_out every cycle.
   - gray_out == bin_out ^ (bin_out >> 1) on every cycle.
   - Hamming distance between successive gray_out values is <= 1 whenever load was 0.
